// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port memory bus.
// Optional bus wait timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module pipeline_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              inst_flush_i,
    output logic              inst_ready_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_stall_o,
    input  logic              data_req_i,
    input  logic              data_write_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [DATA_W/8-1:0] data_wmask_i,
    output logic              data_ready_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_stall_o,
    output logic              bus_req_o,
    output logic              bus_write_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_wmask_o,
    input  logic              bus_ready_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              bus_timeout_o
);

    localparam int unsigned MaskW   = DATA_W / 8;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    if (STARVE_LIMIT == 0 || TIMEOUT_CYCLES == 0) begin : g_param_err
        $error("STARVE_LIMIT and TIMEOUT_CYCLES must both be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q, state_d;
    logic                owner_inst_q, owner_inst_d;
    logic                drop_q, drop_d;
    logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
    logic                bus_write_q, bus_write_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [MaskW-1:0]    bus_wmask_q, bus_wmask_d;
    logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
    logic                inst_ok;
    logic                pick_inst;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            timeout_q, timeout_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_timeout_o = timeout_q;
`else
    assign bus_timeout_o = 1'b0;
`endif

    assign inst_ok   = inst_req_i & ~inst_flush_i;
    // Fetch only beats a pending data request once it has been starved long enough.
    assign pick_inst = inst_ok & (~data_req_i | (starve_cnt_q == StarveW'(STARVE_LIMIT)));

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wmask_d  = bus_wmask_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                drop_d = 1'b0;
                if (data_req_i && !pick_inst && inst_ok &&
                    starve_cnt_q != StarveW'(STARVE_LIMIT)) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end else if (pick_inst || !inst_ok) begin
                    starve_cnt_d = '0;
                end
                if (pick_inst) begin
                    state_d      = StBusy;
                    owner_inst_d = 1'b1;
                    bus_write_d  = 1'b0;
                    bus_addr_d   = inst_addr_i;
                    bus_wdata_d  = '0;
                    bus_wmask_d  = '0;
                end else if (data_req_i) begin
                    state_d      = StBusy;
                    owner_inst_d = 1'b0;
                    bus_write_d  = data_write_i;
                    bus_addr_d   = data_addr_i;
                    bus_wdata_d  = data_wdata_i;
                    bus_wmask_d  = data_wmask_i;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StBusy: begin
                if (owner_inst_q && inst_flush_i) drop_d = 1'b1;
                if (bus_ready_i) begin
                    state_d = StResp;
                    if (owner_inst_q) inst_rdata_d = bus_rdata_i;
                    else              data_rdata_d = bus_rdata_i;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q + 1'b1 == CntW'(TIMEOUT_CYCLES)) begin
                    state_d   = StResp;
                    timeout_d = 1'b1;
                    if (owner_inst_q) inst_rdata_d = '0;
                    else              data_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            owner_inst_q <= 1'b0;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wmask_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wmask_q  <= bus_wmask_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // A flush arriving during the response cycle itself also suppresses the pulse.
    assign inst_ready_o = (state_q == StResp) & owner_inst_q & ~drop_q & ~inst_flush_i;
    assign data_ready_o = (state_q == StResp) & ~owner_inst_q;
    assign inst_stall_o = inst_req_i & ~inst_ready_o;
    assign data_stall_o = data_req_i & ~data_ready_o;
    assign inst_rdata_o = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign bus_req_o    = (state_q == StBusy);
    assign bus_write_o  = bus_write_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign bus_wmask_o  = bus_wmask_q;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed self-checking bench for pipeline_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_pipeline_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        inst_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_flush_i = 1'b0;
    logic        inst_ready_o;
    logic [31:0] inst_rdata_o;
    logic        inst_stall_o;
    logic        data_req_i = 1'b0;
    logic        data_write_i = 1'b0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [3:0]  data_wmask_i = '0;
    logic        data_ready_o;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;
    logic        bus_req_o;
    logic        bus_write_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wmask_o;
    logic        bus_ready_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_timeout_o;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    pipeline_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_flush_i(inst_flush_i),
        .inst_ready_o(inst_ready_o), .inst_rdata_o(inst_rdata_o), .inst_stall_o(inst_stall_o),
        .data_req_i(data_req_i), .data_write_i(data_write_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_wmask_i(data_wmask_i),
        .data_ready_o(data_ready_o), .data_rdata_o(data_rdata_o), .data_stall_o(data_stall_o),
        .bus_req_o(bus_req_o), .bus_write_o(bus_write_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
        .bus_ready_i(bus_ready_i), .bus_rdata_i(bus_rdata_i), .bus_timeout_o(bus_timeout_o)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        total++;
        if ({bus_req_o, bus_write_o, inst_ready_o, data_ready_o, bus_timeout_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus_req_o, bus_write_o, inst_ready_o, data_ready_o, bus_timeout_o});
        end
        total++;
        if ({bus_addr_o, bus_wdata_o, bus_wmask_o, inst_rdata_o, data_rdata_o} !== '0) begin
            bad++;
            $display("FAIL reset_data addr=%h wdata=%h mask=%h irdata=%h drdata=%h want=0",
                     bus_addr_o, bus_wdata_o, bus_wmask_o, inst_rdata_o, data_rdata_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        inst_req_i = 1'b1; inst_addr_i = 32'h100;
        step();
        total++;
        if ({bus_req_o, bus_write_o, bus_addr_o, bus_wmask_o} !== {1'b1, 1'b0, 32'h100, 4'h0}) begin
            bad++;
            $display("FAIL fetch_bus req=%b wr=%b addr=%h mask=%h want 1 0 100 0",
                     bus_req_o, bus_write_o, bus_addr_o, bus_wmask_o);
        end
        total++;
        if (inst_stall_o !== 1'b1) begin
            bad++; $display("FAIL fetch_stall got=%b want=1", inst_stall_o);
        end
        bus_ready_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
        step();
        bus_ready_i = 1'b0;
        total++;
        if ({inst_ready_o, data_ready_o, bus_req_o, inst_stall_o} !== 4'b1000 ||
            inst_rdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_resp irdy=%b drdy=%b breq=%b stall=%b rdata=%h want 1 0 0 0 deadbeef",
                     inst_ready_o, data_ready_o, bus_req_o, inst_stall_o, inst_rdata_o);
        end
        inst_req_i = 1'b0;
        step();
        total++;
        if ({inst_ready_o, bus_req_o} !== 2'b00 || inst_rdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL fetch_pulse_end irdy=%b breq=%b rdata=%h want 0 0 deadbeef",
                     inst_ready_o, bus_req_o, inst_rdata_o);
        end
    endtask

    task automatic test_store();
        data_req_i = 1'b1; data_write_i = 1'b1; data_addr_i = 32'h2004;
        data_wdata_i = 32'h11223344; data_wmask_i = 4'b0011;
        step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({bus_req_o, bus_write_o, bus_addr_o, bus_wdata_o, bus_wmask_o} !==
                {1'b1, 1'b1, 32'h2004, 32'h11223344, 4'b0011}) begin
                bad++;
                $display("FAIL store_bus[%0d] req=%b wr=%b addr=%h wdata=%h mask=%b want 1 1 2004 11223344 0011",
                         i, bus_req_o, bus_write_o, bus_addr_o, bus_wdata_o, bus_wmask_o);
            end
            if (i == 1) begin
                bus_ready_i = 1'b1; bus_rdata_i = 32'hCAFE0000;
            end
            step();
        end
        bus_ready_i = 1'b0;
        total++;
        if ({data_ready_o, inst_ready_o, inst_stall_o} !== 3'b100 ||
            inst_rdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL store_resp drdy=%b irdy=%b istall=%b irdata=%h want 1 0 0 deadbeef",
                     data_ready_o, inst_ready_o, inst_stall_o, inst_rdata_o);
        end
        data_req_i = 1'b0; data_write_i = 1'b0;
        step();
    endtask

    task automatic test_contention();
        logic [9:0] want_inst;
        want_inst = 10'b1000010000;  // bit g set = grant g goes to fetch
        inst_req_i = 1'b1; inst_addr_i = 32'h400;
        data_req_i = 1'b1; data_addr_i = 32'h800;
        for (int g = 0; g < 10; g++) begin
            step();
            total++;
            if (bus_req_o !== 1'b1 ||
                bus_addr_o !== (want_inst[g] ? 32'h400 : 32'h800)) begin
                bad++;
                $display("FAIL contention_grant[%0d] breq=%b addr=%h want 1 %h",
                         g, bus_req_o, bus_addr_o, want_inst[g] ? 32'h400 : 32'h800);
            end
            bus_ready_i = 1'b1; bus_rdata_i = 32'h1000 + g;
            step();
            bus_ready_i = 1'b0;
            total++;
            if ({inst_ready_o, data_ready_o} !== {want_inst[g], ~want_inst[g]}) begin
                bad++;
                $display("FAIL contention_ready[%0d] irdy=%b drdy=%b want %b %b",
                         g, inst_ready_o, data_ready_o, want_inst[g], ~want_inst[g]);
            end
            if (g == 9) begin
                inst_req_i = 1'b0; data_req_i = 1'b0;
            end
            step();
        end
        total++;
        if (bus_req_o !== 1'b0) begin
            bad++; $display("FAIL contention_idle breq=%b want=0", bus_req_o);
        end
    endtask

    task automatic test_flush();
        inst_req_i = 1'b1; inst_addr_i = 32'h300;
        step();
        inst_flush_i = 1'b1; inst_req_i = 1'b0;
        step();
        inst_flush_i = 1'b0;
        step();
        total++;
        if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h300}) begin
            bad++;
            $display("FAIL flush_busy breq=%b addr=%h want 1 300", bus_req_o, bus_addr_o);
        end
        step();
        bus_ready_i = 1'b1; bus_rdata_i = 32'h33333333;
        step();
        bus_ready_i = 1'b0;
        total++;
        if ({inst_ready_o, data_ready_o, bus_req_o} !== 3'b000) begin
            bad++;
            $display("FAIL flush_suppress irdy=%b drdy=%b breq=%b want 0 0 0",
                     inst_ready_o, data_ready_o, bus_req_o);
        end
        step();
        inst_req_i = 1'b1; inst_addr_i = 32'h500;
        step();
        total++;
        if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h500}) begin
            bad++;
            $display("FAIL flush_next_grant breq=%b addr=%h want 1 500", bus_req_o, bus_addr_o);
        end
        bus_ready_i = 1'b1; bus_rdata_i = 32'h000055AA;
        step();
        bus_ready_i = 1'b0;
        total++;
        if (inst_ready_o !== 1'b1 || inst_rdata_o !== 32'h000055AA) begin
            bad++;
            $display("FAIL flush_next_resp irdy=%b rdata=%h want 1 000055aa",
                     inst_ready_o, inst_rdata_o);
        end
        inst_req_i = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        data_req_i = 1'b1; data_write_i = 1'b0; data_addr_i = 32'h900;
        step();
        total++;
        if (bus_req_o !== 1'b1) begin
            bad++; $display("FAIL areset_pre breq=%b want=1", bus_req_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({bus_req_o, data_ready_o, bus_addr_o} !== {1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL areset_drop breq=%b drdy=%b addr=%h want 0 0 0",
                     bus_req_o, data_ready_o, bus_addr_o);
        end
        data_req_i = 1'b0;
        #2 rst_ni = 1'b1;
        step();
        data_req_i = 1'b1; data_addr_i = 32'hA00;
        step();
        total++;
        if ({bus_req_o, bus_addr_o} !== {1'b1, 32'hA00}) begin
            bad++;
            $display("FAIL areset_fresh breq=%b addr=%h want 1 a00", bus_req_o, bus_addr_o);
        end
        bus_ready_i = 1'b1; bus_rdata_i = 32'h1234;
        step();
        bus_ready_i = 1'b0;
        total++;
        if (data_ready_o !== 1'b1 || data_rdata_o !== 32'h1234) begin
            bad++;
            $display("FAIL areset_fresh_resp drdy=%b rdata=%h want 1 1234",
                     data_ready_o, data_rdata_o);
        end
        data_req_i = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        data_req_i = 1'b1; data_addr_i = 32'hB00;
        step();
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step();
        total++;
        if ({bus_req_o, data_ready_o, bus_timeout_o} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_wait breq=%b drdy=%b tmo=%b want 1 0 0",
                     bus_req_o, data_ready_o, bus_timeout_o);
        end
        step();
        total++;
        if ({bus_req_o, data_ready_o, bus_timeout_o} !== 3'b011 || data_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL timeout_fire breq=%b drdy=%b tmo=%b rdata=%h want 0 1 1 0",
                     bus_req_o, data_ready_o, bus_timeout_o, data_rdata_o);
        end
        data_req_i = 1'b0;
        step();
        total++;
        if ({data_ready_o, bus_timeout_o} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_pulse_end drdy=%b tmo=%b want 0 0", data_ready_o, bus_timeout_o);
        end
`else
        for (int i = 0; i < 20; i++) step();
        total++;
        if ({bus_req_o, data_ready_o, bus_timeout_o} !== 3'b100) begin
            bad++;
            $display("FAIL no_timeout_wait breq=%b drdy=%b tmo=%b want 1 0 0",
                     bus_req_o, data_ready_o, bus_timeout_o);
        end
        bus_ready_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        step();
        bus_ready_i = 1'b0;
        total++;
        if (data_ready_o !== 1'b1 || data_rdata_o !== 32'h0BADF00D || bus_timeout_o !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout_resp drdy=%b rdata=%h tmo=%b want 1 0badf00d 0",
                     data_ready_o, data_rdata_o, bus_timeout_o);
        end
        data_req_i = 1'b0;
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_flush();
        test_async_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Shares one single-port memory bus between the pipeline's instruction-fetch port and its data (load/store) port.
- Arbitrates between the two, registers the winning request, and sequences a req/ready handshake on the bus.
- Returns one-cycle response pulses and stall signals to the pipeline control path.
- Sits between the pipeline and the unified memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-mask width is DATA_W/8.
- STARVE_LIMIT, 4, max consecutive data grants while fetch waits; must be >= 1.
- TIMEOUT_CYCLES, 255, bus wait limit when the optional feature is enabled.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- inst_req  in  1  fetch request, held until inst_ready or inst_flush.
- inst_addr  in  ADDR_W  fetch address.
- inst_flush  in  1  pipeline flush; drops any pending or in-flight fetch response.
- inst_ready  out  1  fetch response pulse.
- inst_rdata  out  DATA_W  fetch data, valid with inst_ready.
- inst_stall  out  1  inst_req & ~inst_ready.
- data_req  in  1  load/store request, held until data_ready.
- data_write  in  1  1 = store.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_wmask  in  DATA_W/8  store byte mask.
- data_ready  out  1  data response pulse.
- data_rdata  out  DATA_W  load data, valid with data_ready.
- data_stall  out  1  data_req & ~data_ready.
- bus_req  out  1  bus transaction active.
- bus_write  out  1  registered write flag.
- bus_addr  out  ADDR_W  registered address.
- bus_wdata  out  DATA_W  registered store data.
- bus_wmask  out  DATA_W/8  registered byte mask.
- bus_ready  in  1  bus completion; bus_rdata valid in the same cycle.
- bus_rdata  in  DATA_W  bus read data.
- bus_timeout  out  1  timeout pulse, coincident with the ready pulse.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (async, level-sensitive):
  - State goes to IDLE.
  - All outputs become 0: bus_*, *_ready, *_rdata, bus_timeout.
  - starve_cnt becomes 0; owner becomes DATA.
- IDLE:
  - If any request is present (with inst_req qualified by ~inst_flush), pick a winner, latch its addr/write/wdata/wmask into the bus registers, and go to BUSY. bus_req is 1 from the next cycle.
  - Fetch latches write=0 and wmask=0.
  - Priority: data wins, except fetch wins when both are requesting and starve_cnt == STARVE_LIMIT.
- starve_cnt:
  - Increments on a data grant while inst_req is high.
  - Saturates at STARVE_LIMIT.
  - Clears on a fetch grant, or when IDLE sees inst_req low.
- BUSY:
  - Bus outputs are stable while waiting.
  - When bus_ready=1, capture bus_rdata into the owner's rdata register, drop bus_req next cycle, and go to RESP.
- RESP, one cycle:
  - The owner's ready=1.
  - The other port's ready=0; the non-owner rdata register holds its old value.
  - Requests are ignored. Next state is IDLE.
- Minimum latency: request at cycle 0, bus_req at cycle 1, bus_ready at cycle 1, ready at cycle 2. Back-to-back grants are therefore every 3 cycles.
- Flush:
  - A fetch already in BUSY runs to completion on the bus (no abort).
  - A flush seen in BUSY or RESP sets a drop flag; the RESP inst_ready is suppressed.
  - The drop flag clears on entry to IDLE.
- Data transactions are never cancelled.
- A request deasserted illegally before ready is not tracked: the latched transaction completes and its ready pulse is still issued.
- Address and data are transparent to the arbiter: no alignment checks.
- Reset mid-transaction abandons it; bus_req drops immediately on async assertion.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on BUSY entry and counts each BUSY cycle without bus_ready.
  - On the cycle the count would reach TIMEOUT_CYCLES, drop bus_req and go to RESP.
  - The owner's ready pulse carries rdata=0 with bus_timeout=1 for that cycle.
  - bus_ready coincident with expiry counts as a normal completion.
- Disabled: BUSY waits indefinitely; bus_timeout is tied to 0; the counter is absent.

Test Plan:
- Single fetch: inst_req=1, addr=0x100; bus_ready one cycle after bus_req with rdata=0xDEADBEEF → bus_addr=0x100, bus_write=0; inst_ready pulses exactly 1 cycle with inst_rdata=0xDEADBEEF.
- Store: data_req=1, write=1, addr=0x2004, wdata=0x11223344, wmask=4'b0011 → bus outputs match while BUSY; data_ready pulse; inst signals unaffected.
- Contention, STARVE_LIMIT=4: both ports hold requests continuously → grant order is D,D,D,D,I,D,D,D,D,I.
- Flush: fetch in BUSY, inst_flush pulsed, bus_ready 3 cycles later → bus completes; no inst_ready; next fetch is granted normally.
- Reset: reset=0 asynchronously while BUSY → bus_req=0 and state IDLE before the next clock edge; after release, a fresh request works.
- Timeout, MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: bus_ready never asserted → after 8 BUSY cycles, data_ready=1, bus_timeout=1, data_rdata=0. With the macro undefined, the arbiter stays in BUSY.
